// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master and its clock generator.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        SHIFT_LOW  = 3'd1,
        SHIFT_HIGH = 3'd2,
        CS_HOLD    = 3'd3,
        GAP        = 3'd4
    } state_e;

    localparam int FRAME_BITS = 16;
    localparam int ADDR_BITS  = 7;
    localparam int DATA_BITS  = 8;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    // Assemble the outgoing frame, MSB first: address, R/W, then data (zeros on reads).
    function automatic logic [FRAME_BITS-1:0] build_frame(
        input logic                 rw,
        input logic [ADDR_BITS-1:0] addr,
        input logic [DATA_BITS-1:0] wdata
    );
        logic [DATA_BITS-1:0] payload;
        if (rw == RW_READ) begin
            payload = 8'h00;
        end else begin
            payload = wdata;
        end
        return {addr, rw, payload};
    endfunction

endpackage

// File: rtl/spi_master_if.sv
// Command handshake plus SPI pin bundle between the master and its user/slave.
interface spi_master_if;
    import spi_pkg::*;

    logic                 start;
    logic                 rw;
    logic [ADDR_BITS-1:0] addr;
    logic [DATA_BITS-1:0] wdata;
    logic                 busy;
    logic                 done;
    logic [DATA_BITS-1:0] rdata;
    logic                 sclk;
    logic                 cs;
    logic                 mosi;
    logic                 miso;

    modport master (
        input  start, rw, addr, wdata, miso,
        output busy, done, rdata, sclk, cs, mosi
    );

    modport slave (
        output start, rw, addr, wdata, miso,
        input  busy, done, rdata, sclk, cs, mosi
    );
endinterface

// File: rtl/spi_clkgen.sv
// Half-period counter: cleared by the FSM on every state change, ticks on the
// last clk cycle of each half-period.
module spi_clkgen #(
    parameter int HALF_PERIOD = 50,
    parameter int CNT_WIDTH   = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;

    // Next count: restart on clear, otherwise advance.
    always_comb begin
        if (clr) begin
            cnt_d = {CNT_WIDTH{1'b0}};
        end else begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= {CNT_WIDTH{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == CNT_WIDTH'(HALF_PERIOD - 1));
endmodule

// File: rtl/spi_master.sv
// SPI master issuing one 16-bit frame (addr, R/W, data) per command.
// All pin outputs come straight from flops.
module spi_master
    import spi_pkg::*;
#(
    parameter int HALF_PERIOD = 50,
    parameter int CNT_WIDTH   = 8
) (
    input  logic          clk,
    input  logic          reset,
    spi_master_if.master  bus
);
    state_e                state_q,  state_d;
    logic [3:0]            bit_q,    bit_d;
    logic [FRAME_BITS-1:0] frame_q,  frame_d;
    logic                  rw_q,     rw_d;
    logic [DATA_BITS-1:0]  shadow_q, shadow_d;
    logic [DATA_BITS-1:0]  rdata_q,  rdata_d;
    logic                  sclk_q,   sclk_d;
    logic                  cs_q,     cs_d;
    logic                  mosi_q,   mosi_d;
    logic                  busy_q,   busy_d;
    logic                  done_q,   done_d;
    logic                  tick_s;
    logic                  clr_s;

    // Keep the counter at zero in IDLE and restart it on every state change.
    assign clr_s = (state_d != state_q) || (state_q == IDLE);

    spi_clkgen #(
        .HALF_PERIOD (HALF_PERIOD),
        .CNT_WIDTH   (CNT_WIDTH)
    ) u_clkgen (
        .clk   (clk),
        .reset (reset),
        .clr   (clr_s),
        .tick  (tick_s)
    );

    // Next-state and next-output logic for the frame sequencer.
    always_comb begin
        state_d  = state_q;
        bit_d    = bit_q;
        frame_d  = frame_q;
        rw_d     = rw_q;
        shadow_d = shadow_q;
        rdata_d  = rdata_q;
        sclk_d   = sclk_q;
        cs_d     = cs_q;
        mosi_d   = mosi_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = SHIFT_LOW;
                    frame_d = build_frame(bus.rw, bus.addr, bus.wdata);
                    rw_d    = bus.rw;
                    bit_d   = 4'd0;
                    busy_d  = 1'b1;
                    cs_d    = 1'b0;
                    sclk_d  = 1'b0;
                    mosi_d  = frame_d[FRAME_BITS-1];
                end else begin
                    busy_d  = 1'b0;
                end
            end
            SHIFT_LOW: begin
                if (tick_s) begin
                    state_d = SHIFT_HIGH;
                    sclk_d  = 1'b1;
                end else begin
                    sclk_d  = 1'b0;
                end
            end
            SHIFT_HIGH: begin
                if (tick_s) begin
                    // Sample miso at the very end of the high phase, data half of reads only.
                    if ((rw_q == RW_READ) && bit_q[3]) begin
                        shadow_d = {shadow_q[DATA_BITS-2:0], bus.miso};
                    end else begin
                        shadow_d = shadow_q;
                    end
                    sclk_d = 1'b0;
                    if (bit_q == 4'd15) begin
                        state_d = CS_HOLD;
                        mosi_d  = 1'b0;
                    end else begin
                        state_d = SHIFT_LOW;
                        bit_d   = bit_q + 4'd1;
                        frame_d = {frame_q[FRAME_BITS-2:0], 1'b0};
                        mosi_d  = frame_q[FRAME_BITS-2];
                    end
                end else begin
                    sclk_d = 1'b1;
                end
            end
            CS_HOLD: begin
                if (tick_s) begin
                    state_d = GAP;
                    cs_d    = 1'b1;
                    done_d  = 1'b1;
                    if (rw_q == RW_READ) begin
                        rdata_d = shadow_q;
                    end else begin
                        rdata_d = rdata_q;
                    end
                end else begin
                    cs_d = 1'b0;
                end
            end
            GAP: begin
                if (tick_s) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    busy_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                sclk_d  = 1'b0;
                cs_d    = 1'b1;
                mosi_d  = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Sequencer and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            bit_q    <= 4'd0;
            frame_q  <= {FRAME_BITS{1'b0}};
            rw_q     <= RW_WRITE;
            shadow_q <= {DATA_BITS{1'b0}};
            rdata_q  <= {DATA_BITS{1'b0}};
            sclk_q   <= 1'b0;
            cs_q     <= 1'b1;
            mosi_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            bit_q    <= bit_d;
            frame_q  <= frame_d;
            rw_q     <= rw_d;
            shadow_q <= shadow_d;
            rdata_q  <= rdata_d;
            sclk_q   <= sclk_d;
            cs_q     <= cs_d;
            mosi_q   <= mosi_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.sclk  = sclk_q;
    assign bus.cs    = cs_q;
    assign bus.mosi  = mosi_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.rdata = rdata_q;
endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master with H=4 and a behavioural SPI memory slave.
module tb_spi_master;
    localparam int H = 4;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fails;

    spi_master_if bus_if ();

    spi_master #(
        .HALF_PERIOD (H),
        .CNT_WIDTH   (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural SPI memory: captures mosi on sclk rise, drives miso after falls.
    logic [7:0]  mem [128];
    logic [15:0] rx;
    int          rcnt;
    logic [7:0]  rd_byte;
    logic        rd_en;

    initial begin
        rx = 16'h0000; rcnt = 0; rd_byte = 8'h00; rd_en = 1'b0;
        bus_if.miso = 1'b0;
        for (int i = 0; i < 128; i++) mem[i] = 8'h00;
    end

    always @(posedge bus_if.sclk or negedge bus_if.sclk or posedge bus_if.cs) begin
        if (bus_if.cs === 1'b1) begin
            if (rcnt == 16 && rx[8] == 1'b0) mem[rx[15:9]] = rx[7:0];
            rcnt = 0;
            rd_en = 1'b0;
            bus_if.miso = 1'b0;
        end else if (bus_if.sclk === 1'b1) begin
            rx = {rx[14:0], bus_if.mosi};
            rcnt = rcnt + 1;
        end else begin
            if (rcnt == 8) begin
                rd_byte = mem[rx[7:1]];
                rd_en = rx[0];
            end
            if (rd_en && rcnt >= 8 && rcnt <= 15) begin
                int idx;
                idx = 15 - rcnt;
                bus_if.miso = rd_byte[idx[2:0]];
            end
        end
    end

    // Measure how long cs stays high between frames.
    int cs_high_run;
    int last_gap;
    initial begin cs_high_run = 0; last_gap = 0; end
    always @(posedge clk) begin
        if (bus_if.cs === 1'b1) begin
            cs_high_run <= cs_high_run + 1;
        end else begin
            if (cs_high_run != 0) last_gap <= cs_high_run;
            cs_high_run <= 0;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a command; returns #1 after the accepting edge (cycle T0+1).
    task automatic issue(input logic r, input logic [6:0] a, input logic [7:0] d, input logic hold);
        bus_if.rw    = r;
        bus_if.addr  = a;
        bus_if.wdata = d;
        bus_if.start = 1'b1;
        step();
        if (!hold) bus_if.start = 1'b0;
    endtask

    // Observe cycles T0+1 .. T0+1+34H (inclusive), recording key events.
    int cs_last, done_k, done_cnt, busy_fall;
    logic [7:0] done_rdata;
    task automatic run_frame();
        cs_last = 0; done_k = 0; done_cnt = 0; busy_fall = 0; done_rdata = 8'h00;
        for (int k = 1; k <= 34 * H + 1; k++) begin
            if (k > 1) step();
            if (bus_if.cs === 1'b0) cs_last = k;
            if (bus_if.done === 1'b1) begin
                done_cnt++;
                done_k = k;
                done_rdata = bus_if.rdata;
            end
            if (bus_if.busy === 1'b0 && busy_fall == 0) busy_fall = k;
        end
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        bus_if.start = 1'b0; bus_if.rw = 1'b0; bus_if.addr = 7'h00; bus_if.wdata = 8'h00;

        // Reset
        reset = 1'b1;
        step(); step();
        check_eq("rst_sclk",  {31'd0, bus_if.sclk},  32'd0);
        check_eq("rst_cs",    {31'd0, bus_if.cs},    32'd1);
        check_eq("rst_mosi",  {31'd0, bus_if.mosi},  32'd0);
        check_eq("rst_busy",  {31'd0, bus_if.busy},  32'd0);
        check_eq("rst_done",  {31'd0, bus_if.done},  32'd0);
        check_eq("rst_rdata", {24'd0, bus_if.rdata}, 32'd0);
        reset = 1'b0;
        step();

        // Write addr 2A data C3
        issue(1'b0, 7'h2A, 8'hC3, 1'b0);
        check_eq("wr_busy_t1", {31'd0, bus_if.busy}, 32'd1);
        check_eq("wr_cs_t1",   {31'd0, bus_if.cs},   32'd0);
        check_eq("wr_sclk_t1", {31'd0, bus_if.sclk}, 32'd0);
        check_eq("wr_mosi_t1", {31'd0, bus_if.mosi}, 32'd0);
        run_frame();
        check_eq("wr_frame",     {16'd0, rx},          32'h54C3);
        check_eq("wr_cs_last",   cs_last,              32'd132);
        check_eq("wr_done_k",    done_k,               32'd133);
        check_eq("wr_done_cnt",  done_cnt,             32'd1);
        check_eq("wr_busy_fall", busy_fall,            32'd137);
        check_eq("wr_mem",       {24'd0, mem[7'h2A]},  32'hC3);

        // Read addr 05 returning A5
        mem[7'h05] = 8'hA5;
        issue(1'b1, 7'h05, 8'hFF, 1'b0);
        run_frame();
        check_eq("rd_rdata",    {24'd0, done_rdata},   32'hA5);
        check_eq("rd_hold",     {24'd0, bus_if.rdata}, 32'hA5);
        check_eq("rd_mosi_hdr", {24'd0, rx[15:8]},     32'h0B);
        check_eq("rd_mosi_dat", {24'd0, rx[7:0]},      32'h00);
        check_eq("rd_done_cnt", done_cnt,              32'd1);

        // Write 5A to 11, then read it back back-to-back
        issue(1'b0, 7'h11, 8'h5A, 1'b0);
        run_frame();
        check_eq("wr2_rdata_kept", {24'd0, done_rdata}, 32'hA5);
        issue(1'b1, 7'h11, 8'h00, 1'b0);
        run_frame();
        check_eq("wr_rd_rdata", {24'd0, done_rdata}, 32'h5A);
        check_eq("wr_rd_gap_ok", {31'd0, (last_gap >= H)}, 32'd1);

        // start held high through a frame
        issue(1'b0, 7'h40, 8'h81, 1'b1);
        run_frame();
        check_eq("hold_done_cnt",  done_cnt,  32'd1);
        check_eq("hold_busy_fall", busy_fall, 32'd137);
        step();
        check_eq("hold_rebusy", {31'd0, bus_if.busy}, 32'd1);
        check_eq("hold_recs",   {31'd0, bus_if.cs},   32'd0);
        bus_if.start = 1'b0;
        run_frame();
        check_eq("hold2_done_cnt", done_cnt,            32'd1);
        check_eq("hold2_mem",      {24'd0, mem[7'h40]}, 32'h81);

        // Reset mid-frame at T0+40
        mem[7'h33] = 8'hFF;
        issue(1'b1, 7'h22, 8'h00, 1'b0);
        for (int k = 2; k <= 40; k++) step();
        reset = 1'b1;
        step();
        check_eq("mid_cs",   {31'd0, bus_if.cs},   32'd1);
        check_eq("mid_sclk", {31'd0, bus_if.sclk}, 32'd0);
        check_eq("mid_busy", {31'd0, bus_if.busy}, 32'd0);
        check_eq("mid_done", {31'd0, bus_if.done}, 32'd0);
        reset = 1'b0;
        step();
        check_eq("mid_rdata_clr", {24'd0, bus_if.rdata}, 32'd0);
        issue(1'b1, 7'h33, 8'h00, 1'b0);
        run_frame();
        check_eq("post_rst_rdata",    {24'd0, done_rdata}, 32'hFF);
        check_eq("post_rst_done_cnt", done_cnt,            32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
SPI master that sits directly upstream of the SPI memory block and drives its sclk, cs and mosi pins while sampling its miso pin. A parallel command interface issues one 16-bit frame per transaction. Each frame is a 7-bit address, a R/W bit and 8 data bits. The block serves as the on-FPGA traffic generator and bench driver for the memory. sclk is slow relative to clk so that the slave's input conditioners can resolve every edge.

Parameters:
HALF_PERIOD, 50, clk cycles per sclk half-period; legal values ≥ 2; also sets the cs setup, cs hold and inter-frame gap lengths.
CNT_WIDTH, 8, width of the half-period counter; must satisfy 2^CNT_WIDTH > HALF_PERIOD.

Ports:
clk  input  1  system clock; all logic on its rising edge
reset  input  1  synchronous, active-high reset
start  input  1  command request; sampled only while busy=0
rw  input  1  1=read, 0=write; latched on accept
addr  input  7  memory address; latched on accept
wdata  input  8  write data; latched on accept; ignored for reads
busy  output  1  high from the cycle after accept until the inter-frame gap ends
done  output  1  one-cycle pulse at frame end; rdata valid from this cycle
rdata  output  8  read data; holds its value until the next read's done
sclk  output  1  SPI clock, idle low
cs  output  1  SPI chip select, active low, idle high
mosi  output  1  serial data to slave, MSB first
miso  input  1  serial data from slave

Behaviour:
- Reset values: sclk=0, cs=1, mosi=0, busy=0, done=0, rdata=0, state=IDLE, counters=0.
- Reset mid-frame aborts on the next clk edge to the reset values. No done pulse is issued and the slave sees cs rise.
- Frame bit order, bit 0 first: addr[6]..addr[0], rw, then wdata[7]..wdata[0] for writes or 0s for reads.
- Accept: in IDLE with start=1 at cycle T0, the block latches addr/rw/wdata. At T0+1: busy=1, cs=0, sclk=0, mosi=frame bit 0.
- start while busy=1 is ignored (no queueing).
- Bit i, i=0..15, occupies 2·H cycles (H = HALF_PERIOD):
  - Low phase: H cycles with sclk=0. mosi changes only on the first cycle of the low phase and is stable for the whole bit.
  - High phase: H cycles with sclk=1.
  - The rising edge of bit i is at T0+1+H+2iH; the falling edge of bit i is at T0+1+2(i+1)H.
- MISO sampling: for bits 8..15 of a read, miso is sampled on the last clk cycle of the high phase and shifted into an rdata shadow register MSB first. miso is ignored for writes and for bits 0..7.
- After the falling edge of bit 15: CS_HOLD state, H cycles with sclk=0 and mosi=0.
- At T0+1+33H: cs=1 and done=1 for exactly one cycle.
  - Read: rdata is updated from the shadow register in the same cycle.
  - Write: rdata is unchanged.
- GAP state: H cycles with cs=1 and busy=1, so the slave FSM observes cs high.
- At T0+1+34H: busy=0 and state=IDLE. start is accepted again that cycle, so back-to-back frames are possible.
- States and transitions:
  - IDLE→SHIFT_LOW on accept.
  - SHIFT_LOW→SHIFT_HIGH when the counter reaches H−1.
  - SHIFT_HIGH→SHIFT_LOW when the counter reaches H−1 and bit<15.
  - SHIFT_HIGH→CS_HOLD when the counter reaches H−1 and bit=15.
  - CS_HOLD→GAP after H cycles.
  - GAP→IDLE after H cycles.
- Bit counter is 4 bits wide, increments on each high→low transition, and does not wrap within a frame.
- The half-period counter resets to 0 on every state change.
- sclk, cs and mosi are driven directly from registers, so there are no combinational glitches on the pins.

Decomposition:
- Shared package spi_pkg:
  - State encoding localparams: IDLE, SHIFT_LOW, SHIFT_HIGH, CS_HOLD, GAP.
  - FRAME_BITS=16, ADDR_BITS=7, DATA_BITS=8.
  - RW_READ=1, RW_WRITE=0.
- One natural sub-module, spi_clkgen: the half-period counter. It has a clear input and emits a tick on the last cycle of each half-period. The FSM consumes that tick.

Test Plan:
- Reset: assert reset for 2 cycles -> sclk=0, cs=1, mosi=0, busy=0, done=0, rdata=0.
- Write, H=4, addr=7'h2A, rw=0, wdata=8'hC3:
  - mosi sampled at each sclk rise reads 16'b0101010_0_11000011.
  - cs low from T0+1 to T0+132.
  - done pulse at T0+133.
  - busy falls at T0+137.
- Read, H=4, addr=7'h05, behavioural slave drives 8'hA5 on miso (changing after each falling edge from bit 7 on) -> rdata=8'hA5 at done, mosi=0 for bits 8..15.
- Write addr 7'h11 with 8'h5A, then read addr 7'h11, against spi memory -> rdata=8'h5A. Also check that cs is high for ≥H cycles between the two frames.
- start held high through a whole frame -> exactly one frame per busy interval; the second frame starts at T0+1+34H.
- Reset asserted at T0+40 mid-frame -> cs=1 and sclk=0 on the next cycle, no done pulse. A following read of 8'hFF completes normally.
